// File: rtl/present_byte_io_pkg.sv
// Shared types and sizes for the PRESENT-80 byte-stream wrapper.
package present_byte_io_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } io_state_t;

  localparam int BLK_BYTES = 8;
  localparam int KEY_BYTES = 10;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] BLK_N  = CNT_W'(BLK_BYTES);
  localparam logic [CNT_W-1:0] KEY_N  = CNT_W'(KEY_BYTES);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(BLK_BYTES - 1);

endpackage

// File: rtl/present_byte_shifter.sv
// Byte-wide shift register with parallel load; MSB byte leaves first.
module present_byte_shifter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             shift_en,
  input  logic [7:0]       din,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-9:0], din};
    end
  end

endmodule

// File: rtl/present_byte_io.sv
// Byte-stream loader/unloader around the round-based PRESENT-80 core.
module present_byte_io
  import present_byte_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_key_sel,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [63:0] core_plaintext,
  output logic [79:0] core_key,
  output logic        core_n_reset,
  input  logic [63:0] core_ciphertext,
  input  logic        core_done,
  output logic        busy,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  io_state_t        state_q;
  io_state_t        state_n;
  logic [CNT_W-1:0] pt_cnt_q;
  logic [CNT_W-1:0] key_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [TW-1:0]    timer_q;
  logic             core_n_reset_q;
  logic             error_q;

  logic [63:0] pt_q;
  logic [79:0] key_q;
  logic [63:0] ct_q;

  logic key_full;
  logic pt_room;
  logic go;
  logic acc;
  logic key_shift;
  logic pt_shift;
  logic in_wait;
  logic capture;
  logic timeout;
  logic out_hs;
  logic last_out;

  assign key_full  = (key_cnt_q == KEY_N);
  assign pt_room   = (pt_cnt_q < BLK_N);
  assign go        = (state_q == ST_COLLECT)
                   & (pt_cnt_q == BLK_N) & key_full;

  // No byte is taken in the cycle that commits to a launch.
  assign in_ready  = n_reset & (state_q == ST_COLLECT) & ~go
                   & (in_key_sel | pt_room);
  assign acc       = in_valid & in_ready;
  assign key_shift = acc & in_key_sel;
  assign pt_shift  = acc & ~in_key_sel;

  assign in_wait   = (state_q == ST_WAIT);
  assign capture   = in_wait & core_done;
  assign timeout   = in_wait & ~core_done & (timer_q == T_LAST);

  assign out_valid = (state_q == ST_DRAIN);
  assign out_hs    = out_valid & out_ready;
  assign last_out  = out_hs & (out_cnt_q == OUT_LAST);
  assign out_data  = out_valid ? ct_q[63:56] : 8'h00;

  assign busy           = (state_q != ST_COLLECT);
  assign error          = error_q;
  assign core_n_reset   = core_n_reset_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_COLLECT: if (go) state_n = ST_LAUNCH;
      ST_LAUNCH:  state_n = ST_WAIT;
      ST_WAIT: begin
        if (core_done)    state_n = ST_DRAIN;
        else if (timeout) state_n = ST_COLLECT;
      end
      ST_DRAIN:   if (last_out) state_n = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= ST_COLLECT;
      pt_cnt_q       <= '0;
      key_cnt_q      <= '0;
      out_cnt_q      <= '0;
      timer_q        <= '0;
      core_n_reset_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_n;
      // Core reset is low exactly while the FSM sits in LAUNCH.
      core_n_reset_q <= (state_n != ST_LAUNCH);
      timer_q        <= in_wait ? timer_q + 1'b1 : '0;
      if (timeout)
        error_q <= 1'b1;
      if (timeout || last_out)
        pt_cnt_q <= '0;
      else if (pt_shift)
        pt_cnt_q <= pt_cnt_q + 1'b1;
      if (key_shift && !key_full)
        key_cnt_q <= key_cnt_q + 1'b1;
      if (last_out)
        out_cnt_q <= '0;
      else if (out_hs)
        out_cnt_q <= out_cnt_q + 1'b1;
    end
  end

  present_byte_shifter #(.WIDTH(80)) u_key (
    .clk       (clk),
    .n_reset   (n_reset),
    .shift_en  (key_shift),
    .din       (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .q         (key_q)
  );

  present_byte_shifter #(.WIDTH(64)) u_pt (
    .clk       (clk),
    .n_reset   (n_reset),
    .shift_en  (pt_shift),
    .din       (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .q         (pt_q)
  );

  present_byte_shifter #(.WIDTH(64)) u_ct (
    .clk       (clk),
    .n_reset   (n_reset),
    .shift_en  (out_hs),
    .din       (8'h00),
    .load_en   (capture),
    .load_data (core_ciphertext),
    .q         (ct_q)
  );

endmodule
